// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data memory responder.
package data_mem_responder_pkg;
  localparam int WORD_W = 16;
  localparam int LAT_DEF = 4;
  localparam int DEPTH_LOG2_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Word array: synchronous write, combinational read, contents never reset.
module mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);
  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding fixed-latency load/store responder over a word array.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int LAT        = LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  state_t                state;
  logic [3:0]            cnt;
  logic                  lat_wr;
  logic                  lat_oor;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [WORD_W-1:0]     lat_wdata;
  logic [WORD_W-1:0]     mem_rdata;
  logic                  accept;
  logic                  fire;
  logic                  req_oor;
  logic                  mem_we;

  assign req_ready = (state != WAIT);
  assign busy      = (state == WAIT);
  assign accept    = req_valid & req_ready;
  // The edge leaving RESP is the N+LAT edge: commit / capture happen there.
  assign fire      = (state == RESP);
  assign req_oor   = (req_addr >> (DEPTH_LOG2 + 1)) != '0;
  assign mem_we    = fire & lat_wr & ~lat_oor;

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (lat_idx),
    .wdata(lat_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_oor   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= fire;
      rsp_err   <= fire & lat_oor;
      rsp_rdata <= (fire & ~lat_wr & ~lat_oor) ? mem_rdata : '0;
      if (accept) begin
        lat_wr    <= req_wr;
        lat_oor   <= req_oor;
        lat_idx   <= req_addr[DEPTH_LOG2:1];
        lat_wdata <= req_wdata;
        cnt       <= 4'(LAT - 1);
        state     <= (LAT > 1) ? WAIT : RESP;
      end else begin
        unique case (state)
          WAIT: begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RESP;
          end
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
